// File: rtl/jstk_pkg.sv
// jstk_pkg: shared constants, FSM state type and TX frame packing for the
// PmodJSTK responder (jstk_responder).
// Contents:
//   JSTK_FRAME_BYTES / JSTK_FRAME_BITS  frame geometry (5 bytes, 40 bits)
//   JSTK_LED_CMD_PREFIX                 upper six bits of a valid LED command
//   JSTK_BTN_*                          bit positions inside `buttons`
//   jstk_state_t                        responder FSM states
//   jstk_tx_frame()                     builds the 40-bit TX word, byte 0 in [39:32]
package jstk_pkg;

    localparam int         JSTK_FRAME_BYTES    = 5;
    localparam int         JSTK_FRAME_BITS     = 40;
    localparam logic [5:0] JSTK_LED_CMD_PREFIX = 6'b100000;

    localparam int JSTK_BTN_STICK = 0;
    localparam int JSTK_BTN_1     = 1;
    localparam int JSTK_BTN_2     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } jstk_state_t;

    // Byte order on the wire: x[7:0], x[9:8], y[7:0], y[9:8], buttons.
    function automatic logic [39:0] jstk_tx_frame(input logic [9:0] x,
                                                  input logic [9:0] y,
                                                  input logic [2:0] btn);
        return {x[7:0], 6'b0, x[9:8],
                y[7:0], 6'b0, y[9:8],
                5'b0, btn[JSTK_BTN_2], btn[JSTK_BTN_1], btn[JSTK_BTN_STICK]};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: STAGES-deep synchronizer for an asynchronous pin, followed by
// a one-flop edge detector on the synchronized level.
// Ports:
//   clk, rst  fabric clock, synchronous active-high reset
//   din       asynchronous input pin
//   rise      one-cycle pulse on a synchronized 0->1 transition
//   fall      one-cycle pulse on a synchronized 1->0 transition
// The chain and the edge flop both reset to 0, so a pin that is already low
// at reset produces no fall pulse; only a genuine high->low later does.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
            prev <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~prev;
    assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/jstk_responder.sv
// jstk_responder: SPI mode-0 responder emulating the PmodJSTK joystick.
// Answers each 40-bit frame with a snapshot of x/y/buttons and decodes the
// LED command carried in the first received byte.
// Ports:
//   clk, rst      fabric clock, synchronous active-high reset
//   SS            slave select, active low
//   SCLK, MOSI    SPI clock and initiator data
//   MISO          responder data, MSB first
//   x_pos, y_pos  10-bit joystick position, sampled at SS fall
//   buttons       {BTN2, BTN1, stick click}
//   led           last committed LED command
//   frame_done    one-cycle pulse when the 40th SCLK rise is processed
// Configuration macro: JSTK_RESPONDER_LED_EN compiles in the RX shift
// register, command decode and led register; without it led is 2'b00 and
// MOSI is ignored.
module jstk_responder
    import jstk_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SS,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] buttons,
    output logic [1:0] led,
    output logic       frame_done
);

    localparam int BIT_W  = $clog2(JSTK_FRAME_BITS + 1);
    localparam int BYTE_W = $clog2(JSTK_FRAME_BYTES + 1);

    logic ss_rise, ss_fall, sclk_rise, sclk_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (SS),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (SCLK),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    jstk_state_t       state;
    logic [39:0]       tx;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BYTE_W-1:0] byte_cnt;
    logic              miso_r;
    logic              frame_done_r;
    logic              last_rise;
    logic [39:0]       tx_load;

    assign tx_load   = jstk_tx_frame(x_pos, y_pos, buttons);
    assign last_rise = (bit_cnt == BIT_W'(JSTK_FRAME_BITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            tx           <= '0;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            miso_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state)
                IDLE: begin
                    miso_r <= 1'b0;
                    if (ss_fall) begin
                        tx       <= tx_load;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        miso_r   <= tx_load[39];
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // SS release beats a coincident SCLK rise.
                    if (ss_rise) begin
                        miso_r <= 1'b0;
                        state  <= IDLE;
                    end else if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt[2:0] == 3'd7) byte_cnt <= byte_cnt + 1'b1;
                        // frame_done is raised on the same edge that counts
                        // the 40th rise, keeping it SYNC_STAGES+1 clk after
                        // the pin edge.
                        if (last_rise) begin
                            frame_done_r <= 1'b1;
                            miso_r       <= 1'b0;
                            state        <= DONE;
                        end
                    end else if (sclk_fall) begin
                        tx     <= {tx[38:0], 1'b0};
                        miso_r <= tx[38];
                    end
                end
                DONE: begin
                    miso_r <= 1'b0;
                    if (ss_rise) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign MISO       = miso_r;
    assign frame_done = frame_done_r;

`ifdef JSTK_RESPONDER_LED_EN
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [7:0]             rx_byte;
    logic [7:0]             rx_next;
    logic                   cmd_pend;
    logic [1:0]             cmd_led;
    logic [1:0]             led_r;

    // MOSI runs through the same depth as SCLK so the bit seen with a
    // sclk_rise pulse is the one that was on the pin at the SCLK edge.
    assign rx_next = {rx_byte[6:0], mosi_sync[SYNC_STAGES-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_sync <= '0;
            rx_byte   <= '0;
            cmd_pend  <= 1'b0;
            cmd_led   <= 2'b00;
            led_r     <= 2'b00;
        end else begin
            mosi_sync[0] <= MOSI;
            for (int i = 1; i < SYNC_STAGES; i++) mosi_sync[i] <= mosi_sync[i-1];

            if (state == IDLE && ss_fall) begin
                rx_byte  <= '0;
                cmd_pend <= 1'b0;
            end else if (state == SHIFT && ss_rise) begin
                cmd_pend <= 1'b0;
            end else if (state == SHIFT && sclk_rise) begin
                rx_byte <= rx_next;
                if (byte_cnt == '0 && bit_cnt[2:0] == 3'd7 &&
                    rx_next[7:2] == JSTK_LED_CMD_PREFIX) begin
                    cmd_pend <= 1'b1;
                    cmd_led  <= rx_next[1:0];
                end
                if (last_rise && cmd_pend) led_r <= cmd_led;
            end
        end
    end

    assign led = led_r;
`else
    logic unused_mosi;
    assign unused_mosi = MOSI;
    assign led         = 2'b00;
`endif

endmodule
